ab_gen: RTL
===========

AB_GEN -- requirements
Module: ab_gen

Interface
REQ-001 SHALL have parameter AW, default 16, full address width (AW > LW).
REQ-002 SHALL have parameter LW, default 8, low-part and data bus width.
REQ-003 SHALL have parameter FIX_PAGE, default 1, 1 = page-cross fixup costs an extra cycle, 0 = full-width add in one cycle.
REQ-004 SHALL have parameter STACK_PAGE, default 1, high part used for stack accesses.
REQ-005 SHALL have parameter RESET_AB, default 16'hFFFC, address bus value after reset.
REQ-006 clk  in  1  single clock, all state updates on rising edge.
REQ-007 rst_n  in  1  synchronous, active-low reset.
REQ-008 rdy  in  1  high = advance, low = freeze all registers and state.
REQ-009 CI  in  1  carry into low adder.
REQ-010 cond  in  1  condition code, selects branch base.
REQ-011 DB  in  LW  data bus.
REQ-012 REG  in  LW  register file output.
REQ-013 op  in  5  address operation.
REQ-014 ld_ahl / ld_ahh  in  1 each  load AH low / AH high part from DB.
REQ-015 ld_pc  in  1  load PC from AB + inc_pc.
REQ-016 inc_pc  in  1  increment when loading PC.
REQ-017 AB  out  AW  registered address bus.
REQ-018 PC  out  AW  program counter.
REQ-019 AH  out  AW  address hold register.
REQ-020 CO  out  1  combinational carry out of low adder.
REQ-021 stall  out  1  high during page-fixup cycle, the core SHALL not advance its sequencer.

Function
REQ-022 Base select on {cond, op[3:2]}: ?00 -> 0, ?01 -> PC low, ?10 -> AH low, 011 -> 0, 111 -> DB (branch).
REQ-023 Low sum {CO, lo}, LW+1 bits, by op[1:0]: 00 REG+CI, 01 base+REG+CI, 10 base+CI, 11 base+AB low+CI.
REQ-024 High source: op[1:0]=00 -> op[4] ? STACK_PAGE : 0; otherwise base select 00 -> 0, 01 -> PC high, 10 -> AH high, 11 (either cond) -> AB high.
REQ-025 Zero-page form (base select 00) SHALL wrap within the page, no high adjust.
REQ-026 Linear form (op[1:0]=10, or 11 with cond=0) SHALL add CO into the high part in the same cycle, no stall.
REQ-027 Indexed form (op[1:0]=01, base PC/AH) and branch form (cond=1, op[3:2]=11, op[1:0]=11) SHALL apply high adjust adj: indexed adj = CO, branch adj = CO - DB[LW-1] (values +1, 0, -1).
REQ-028 FIX_PAGE=0: AB <= {high + adj, lo} in one cycle, stall never asserted.
REQ-029 FIX_PAGE=1, state RUN: AB <= {high, lo}; if adj != 0, latch adj and go to FIX, else stay in RUN.
REQ-030 State FIX: stall=1 (registered, asserted the cycle after the crossing); AB high <= AB high + latched adj, AB low held; op, CI, cond, ld_pc ignored; return to RUN.
REQ-031 ld_ahl / ld_ahh SHALL still take effect in FIX.
REQ-032 PC <= AB + inc_pc (full AW width, wraps at 2^AW) when ld_pc and rdy and state RUN.
REQ-033 rdy=0: AB, PC, AH, state and stall SHALL hold, and CO still reflects current inputs.
REQ-034 All high-part arithmetic SHALL be modulo 2^(AW-LW).

Reset
REQ-035 rst_n=0 at a clock edge SHALL set AB=RESET_AB, PC=0, AH=0, state RUN, stall=0, overriding rdy and any FIX in progress.
REQ-036 The first edge with rst_n=1 SHALL resume normal operation from RUN.

Verification
REQ-037 AH=16'h12F0, REG=8'h20, op=5'b01001 (AH+REG), CI=0 -> AB=16'h1210, CO=1, next cycle stall=1, AB=16'h1310, then stall=0.
REQ-038 Same as REQ-037 with FIX_PAGE=0 -> AB=16'h1310 in one cycle, stall stays 0.
REQ-039 AB=16'h3402, branch with DB=8'hFA, CI=0 -> AB=16'h34FC, then FIX with adj=-1 -> AB=16'h33FC.
REQ-040 REG=8'hFD, op[4]=1, op[1:0]=00 -> AB=16'h01FD (stack page); op[4]=0 -> 16'h00FD.
REQ-041 AB=16'h20FF, ld_pc=1, inc_pc=1 -> PC=16'h2100.
REQ-042 Enter FIX, assert rst_n=0 the same cycle -> AB=16'hFFFC, stall=0; rdy=0 during FIX -> stall and AB frozen until rdy=1.

Source files
------------

// File: rtl/ab_gen.sv
// Address bus generator: forms the next address from a selectable base plus
// register/offset, with an optional extra cycle to fix up the high part on a page cross.
module ab_gen #(
    parameter int              AW         = 16,
    parameter int              LW         = 8,
    parameter int              FIX_PAGE   = 1,
    parameter int              STACK_PAGE = 1,
    parameter logic [AW-1:0]   RESET_AB   = 16'hFFFC
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          rdy,
    input  logic          CI,
    input  logic          cond,
    input  logic [LW-1:0] DB,
    input  logic [LW-1:0] REG,
    input  logic [4:0]    op,
    input  logic          ld_ahl,
    input  logic          ld_ahh,
    input  logic          ld_pc,
    input  logic          inc_pc,
    output logic [AW-1:0] AB,
    output logic [AW-1:0] PC,
    output logic [AW-1:0] AH,
    output logic          CO,
    output logic          stall
);

    localparam int HW = AW - LW;

    typedef enum logic {
        ST_RUN = 1'b0,
        ST_FIX = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] ab_q, ab_d;
    logic [AW-1:0] pc_q, pc_d;
    logic [AW-1:0] ah_q, ah_d;
    logic          adj_up_q, adj_up_d;
    logic          adj_dn_q, adj_dn_d;

    logic [LW-1:0] base_lo;
    logic [HW-1:0] hi_src;
    logic [LW:0]   lo_sum;
    logic          form_zp, form_lin, form_idx, form_brn;
    logic          adj_up, adj_dn;
    logic [HW-1:0] hi_lin;

    // Adds +1, 0 or -1 to a high part, wrapping modulo 2^HW.
    function automatic logic [HW-1:0] hi_step(input logic [HW-1:0] h,
                                              input logic          up,
                                              input logic          dn);
        if (up)
            return h + HW'(1);
        else if (dn)
            return h - HW'(1);
        else
            return h;
    endfunction

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        base_lo = '0;
        case (op[3:2])
            2'b01:   base_lo = pc_q[LW-1:0];
            2'b10:   base_lo = ah_q[LW-1:0];
            2'b11:   base_lo = cond ? DB : '0;
            default: base_lo = '0;
        endcase

        lo_sum = '0;
        case (op[1:0])
            2'b00:   lo_sum = {1'b0, REG} + (LW+1)'(CI);
            2'b01:   lo_sum = {1'b0, base_lo} + {1'b0, REG} + (LW+1)'(CI);
            2'b10:   lo_sum = {1'b0, base_lo} + (LW+1)'(CI);
            default: lo_sum = {1'b0, base_lo} + {1'b0, ab_q[LW-1:0]} + (LW+1)'(CI);
        endcase

        hi_src = '0;
        if (op[1:0] == 2'b00) begin
            hi_src = op[4] ? HW'(STACK_PAGE) : '0;
        end else begin
            case (op[3:2])
                2'b01:   hi_src = pc_q[AW-1:LW];
                2'b10:   hi_src = ah_q[AW-1:LW];
                2'b11:   hi_src = ab_q[AW-1:LW];
                default: hi_src = '0;
            endcase
        end
    end

    assign CO = lo_sum[LW];

    // Zero-page (base 0) wraps inside the page; the other forms differ only in
    // whether the carry is folded in now (linear) or applied as a page adjust.
    assign form_zp  = (op[3:2] == 2'b00);
    assign form_lin = !form_zp && ((op[1:0] == 2'b10) || ((op[1:0] == 2'b11) && !cond));
    assign form_idx = (op[1:0] == 2'b01) && ((op[3:2] == 2'b01) || (op[3:2] == 2'b10));
    assign form_brn = cond && (op[3:2] == 2'b11) && (op[1:0] == 2'b11);

    assign adj_up = (form_idx && CO) || (form_brn && CO && !DB[LW-1]);
    assign adj_dn = form_brn && !CO && DB[LW-1];
    assign hi_lin = hi_src + HW'(form_lin && CO);

    always_comb begin
        state_d  = state_q;
        ab_d     = ab_q;
        pc_d     = pc_q;
        ah_d     = ah_q;
        adj_up_d = adj_up_q;
        adj_dn_d = adj_dn_q;

        if (rdy) begin
            if (ld_ahl)
                ah_d[LW-1:0] = DB;
            if (ld_ahh)
                ah_d[AW-1:LW] = HW'(DB);

            if (state_q == ST_RUN) begin
                if (FIX_PAGE == 0) begin
                    ab_d = {hi_step(hi_lin, adj_up, adj_dn), lo_sum[LW-1:0]};
                end else begin
                    ab_d = {hi_lin, lo_sum[LW-1:0]};
                    if (adj_up || adj_dn) begin
                        adj_up_d = adj_up;
                        adj_dn_d = adj_dn;
                        state_d  = ST_FIX;
                    end
                end
                if (ld_pc)
                    pc_d = ab_q + {{(AW-1){1'b0}}, inc_pc};
            end else begin
                ab_d    = {hi_step(ab_q[AW-1:LW], adj_up_q, adj_dn_q), ab_q[LW-1:0]};
                state_d = ST_RUN;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_RUN;
            ab_q     <= RESET_AB;
            pc_q     <= '0;
            ah_q     <= '0;
            adj_up_q <= 1'b0;
            adj_dn_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            ab_q     <= ab_d;
            pc_q     <= pc_d;
            ah_q     <= ah_d;
            adj_up_q <= adj_up_d;
            adj_dn_q <= adj_dn_d;
        end
    end

    assign AB    = ab_q;
    assign PC    = pc_q;
    assign AH    = ah_q;
    assign stall = (state_q == ST_FIX);

endmodule
